x4_change_capture: RTL and testbench
====================================

Name: x4_change_capture

Overview:
- Downstream capture stage for the x4 control-logic benchmark.
- Samples the 71-bit x4 output vector (z2..o5, packed in x4 port-declaration order, z2 = bit 0) when the vector is valid.
- Records only vectors that differ from the previously sampled one, tagging each with a free-running timestamp.
- Queues records in a small FIFO and drains them over a valid/ready interface to a logger or scoreboard.

Parameters:
- WIDTH, 71, captured vector width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TS_W, 16, timestamp width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_vec is valid this cycle.
- in_vec  in  WIDTH  x4 output vector.
- clr_stat  in  1  clears overflow and drop_count.
- out_valid  out  1  FIFO head record is available.
- out_ready  in  1  consumer accepts the head record.
- out_vec  out  WIDTH  head record vector.
- out_ts  out  TS_W  head record timestamp.
- out_first  out  1  head record is the first capture since reset.
- fifo_level  out  $clog2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky; set when a record is dropped.
- drop_count  out  8  dropped records, saturating at 255.

Behaviour:
- Reset values (sync, rst=1 at an edge): all outputs 0; ts=0; prev=0; seen=0; FIFO empty, pointers 0. rst dominates every other input in that cycle.
- Timestamp: ts increments by 1 every non-reset cycle and wraps 2^TS_W-1 -> 0. A record's ts is the counter value in the cycle in_vec was sampled.
- Change detect: event = in_valid & (~seen | in_vec != prev).
  - On in_valid: prev <= in_vec and seen <= 1, whether or not the record is stored.
  - in_valid=0: no compare, no state change except ts.
- Record fields: {in_vec, ts, first}. first=1 only when seen==0 at sampling.
- Push/pop:
  - pop = out_valid & out_ready.
  - Push accepted if event and (level < DEPTH or pop). Full + simultaneous pop + push: both occur, level stays DEPTH.
  - Pop on empty is impossible because out_valid=0.
  - Push into empty FIFO: record visible on out_* at the next edge (1-cycle latency); no same-cycle bypass.
- Outputs: out_valid = (level != 0). out_vec, out_ts, out_first come from head storage registers and stay stable while out_valid & ~out_ready.
- Pointers: wrap modulo DEPTH. level updates as +1 on push only, -1 on pop only, unchanged on both or neither.
- Drop: event, full, and no pop.
  - Record discarded; overflow <= 1; drop_count <= min(drop_count+1, 255).
  - prev is still updated, so the next compare uses the dropped vector.
- clr_stat: overflow <= 0 and drop_count <= 0. If a drop occurs in the same cycle: overflow <= 1, drop_count <= 1.
- Reset mid-operation: FIFO contents are discarded (level=0, out_valid=0 next cycle). The next valid sample is treated as first.

Test Plan:
- Reset, then in_valid=1 with in_vec=0 at ts=3 -> next cycle out_valid=1, out_vec=0, out_ts=3, out_first=1, fifo_level=1.
- Same vector 0x1 held for 10 valid cycles with out_ready=1 -> exactly one record; fifo_level returns to 0; drop_count=0.
- out_ready=0; present 6 distinct vectors A..F on consecutive cycles -> A..D stored (level=4), E and F dropped; overflow=1, drop_count=2. Then G (distinct from F) with out_ready=1 -> pops A and pushes G; level stays 4. Drain order: B, C, D, G.
- 300 drops with out_ready=0 -> drop_count=255 saturated. clr_stat pulsed with no drop -> overflow=0, drop_count=0. clr_stat coincident with a drop -> overflow=1, drop_count=1.
- ts at 0xFFFF when a change is sampled, next change one cycle later -> records carry out_ts=0xFFFF then 0x0000.
- rst asserted with 3 entries queued -> next cycle out_valid=0, fifo_level=0. Resample of the vector held before reset -> record stored with out_first=1.

Source files
------------

// File: rtl/x4_change_capture.sv
// Change-capture stage for the x4 output vector: stores only vectors that differ
// from the previous sample, timestamps them, and queues them for a valid/ready consumer.
module x4_change_capture #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_vec,
  input  logic                       clr_stat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_vec,
  output logic [TS_W-1:0]            out_ts,
  output logic                       out_first,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [TS_W-1:0]  ts;
  logic [WIDTH-1:0] prev;
  logic             seen;

  logic [WIDTH-1:0] mem_vec   [DEPTH];
  logic [TS_W-1:0]  mem_ts    [DEPTH];
  logic             mem_first [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  logic chg;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // The first valid sample after reset always counts as a change.
  assign chg  = in_valid & (~seen | (in_vec != prev));
  assign full = (level == FULL_LVL);
  assign pop  = out_valid & out_ready;
  assign push = chg & (~full | pop);
  assign drop = chg & full & ~pop;

  assign out_valid  = (level != '0);
  assign out_vec    = mem_vec[rd_ptr];
  assign out_ts     = mem_ts[rd_ptr];
  assign out_first  = mem_first[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts   <= '0;
      prev <= '0;
      seen <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (in_valid) begin
        prev <= in_vec;
        seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_vec[i]   <= '0;
        mem_ts[i]    <= '0;
        mem_first[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem_vec[wr_ptr]   <= in_vec;
        mem_ts[wr_ptr]    <= ts;
        mem_first[wr_ptr] <= ~seen;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as clr_stat is counted after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_stat) begin
      overflow   <= drop;
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_x4_change_capture.sv
// Self-checking bench for x4_change_capture: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_x4_change_capture;

  localparam int WIDTH = 71;
  localparam int DEPTH = 4;
  localparam int TS_W  = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [WIDTH-1:0]  in_vec;
  logic              clr_stat;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_vec;
  logic [TS_W-1:0]   out_ts;
  logic              out_first;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic [7:0]        drop_count;

  x4_change_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .clr_stat(clr_stat),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_ts(out_ts),
    .out_first(out_first), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] vec;
    logic [TS_W-1:0]  ts;
    logic             first;
  } rec_t;

  rec_t             mq[$];
  logic [TS_W-1:0]  m_ts;
  logic [WIDTH-1:0] m_prev;
  bit               m_seen;
  bit               m_ovf;
  int               m_drops;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a record queue plus the change/drop rules, evaluated once per clock.
  task automatic modelStep(input bit r, input bit iv, input logic [WIDTH-1:0] v,
                           input bit rdy, input bit clr);
    bit   pop, chg, full, drop;
    rec_t rec;
    if (r) begin
      mq.delete();
      m_ts = '0; m_prev = '0; m_seen = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    chg  = iv && (!m_seen || v != m_prev);
    drop = chg && full && !pop;
    if (pop) rec = mq.pop_front();
    if (chg && !drop) begin
      rec.vec = v; rec.ts = m_ts; rec.first = !m_seen;
      mq.push_back(rec);
    end
    if (clr) begin
      m_ovf = drop; m_drops = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1; m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    end
    if (iv) begin
      m_prev = v; m_seen = 1;
    end
    m_ts = m_ts + 1'b1;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    checkOutput("fifo_level", 128'(fifo_level), 128'(mq.size()));
    checkOutput("overflow", 128'(overflow), 128'(m_ovf));
    checkOutput("drop_count", 128'(drop_count), 128'(m_drops));
    if (mq.size() != 0) begin
      checkOutput("out_vec", 128'(out_vec), 128'(mq[0].vec));
      checkOutput("out_ts", 128'(out_ts), 128'(mq[0].ts));
      checkOutput("out_first", 128'(out_first), 128'(mq[0].first));
    end
  endtask

  // Drives one cycle from a negedge, advances the model, checks at the next negedge.
  task automatic applyStimulus(input bit r, input bit iv, input logic [WIDTH-1:0] v,
                               input bit rdy, input bit clr);
    rst = r; in_valid = iv; in_vec = v; out_ready = rdy; clr_stat = clr;
    modelStep(r, iv, v, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic drainAll();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) applyStimulus(0, 0, '0, 1, 0);
  endtask

  function automatic logic [WIDTH-1:0] randVec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] order [4];
  logic [WIDTH-1:0] pool  [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0; clr_stat = 1'b0;
    @(negedge clk);

    // Reset state, then first capture at ts=3.
    applyStimulus(1, 0, '0, 0, 0);
    checkOutput("reset_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_level", 128'(fifo_level), 128'(0));
    checkOutput("reset_drops", 128'(drop_count), 128'(0));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 1, '0, 0, 0);
    checkOutput("first_valid", 128'(out_valid), 128'(1));
    checkOutput("first_ts", 128'(out_ts), 128'(16'd3));
    checkOutput("first_flag", 128'(out_first), 128'(1));
    checkOutput("first_level", 128'(fifo_level), 128'(1));

    // Same vector held: a single record.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 71'h1, 1, 0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("hold_level", 128'(fifo_level), 128'(0));
    checkOutput("hold_drops", 128'(drop_count), 128'(0));

    // Fill, drop two, then simultaneous pop+push at full.
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 71'(10 + i), 0, 0);
    checkOutput("fill_level", 128'(fifo_level), 128'(4));
    checkOutput("fill_ovf", 128'(overflow), 128'(1));
    checkOutput("fill_drops", 128'(drop_count), 128'(2));
    applyStimulus(0, 1, 71'd16, 1, 0);
    checkOutput("pushpop_level", 128'(fifo_level), 128'(4));
    order[0] = 71'd11; order[1] = 71'd12; order[2] = 71'd13; order[3] = 71'd16;
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_order", 128'(out_vec), 128'(order[k]));
      applyStimulus(0, 0, '0, 1, 0);
    end

    // Saturation and clr_stat interactions.
    applyStimulus(0, 0, '0, 0, 1);
    for (int i = 0; i < 304; i++) applyStimulus(0, 1, 71'(100 + i), 0, 0);
    checkOutput("sat_drops", 128'(drop_count), 128'(255));
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("clr_ovf", 128'(overflow), 128'(0));
    checkOutput("clr_drops", 128'(drop_count), 128'(0));
    applyStimulus(0, 1, 71'd999, 0, 1);
    checkOutput("clrdrop_ovf", 128'(overflow), 128'(1));
    checkOutput("clrdrop_drops", 128'(drop_count), 128'(1));
    drainAll();

    // Timestamp wrap between two consecutive captures.
    for (int i = 0; i < 70000 && m_ts != 16'hFFFF; i++) applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(0, 1, 71'h5A5A, 0, 0);
    applyStimulus(0, 1, 71'hA5A5, 0, 0);
    checkOutput("wrap_ts_hi", 128'(out_ts), 128'(16'hFFFF));
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("wrap_ts_lo", 128'(out_ts), 128'(16'h0000));
    drainAll();

    // Reset with entries queued; the held vector is captured again as first.
    applyStimulus(0, 1, 71'h111, 0, 0);
    applyStimulus(0, 1, 71'h222, 0, 0);
    applyStimulus(0, 1, 71'h333, 0, 0);
    checkOutput("pre_rst_level", 128'(fifo_level), 128'(3));
    applyStimulus(1, 1, 71'h444, 1, 1);
    checkOutput("rst_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_level", 128'(fifo_level), 128'(0));
    applyStimulus(0, 1, 71'h333, 0, 0);
    checkOutput("resample_first", 128'(out_first), 128'(1));
    checkOutput("resample_vec", 128'(out_vec), 128'(71'h333));

    // Random traffic over a small vector pool so repeats are common.
    for (int k = 0; k < 4; k++) pool[k] = randVec();
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(9) < 7),
                    pool[$urandom_range(3)], ($urandom_range(1) == 1),
                    ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
